matmul_flags_collector: RTL and testbench

- Sits directly upstream of the matmul flags register and produces that register's write strobe and flag vector.
- Gathers per-PE overflow/underflow strobes from the systolic array during one matmul operation into sticky bits.
- Waits a fixed pipeline-drain interval after the array signals done, then commits all flags in a single write-enable pulse.

---
 rtl/matmul_flags_collector_pkg.sv | 15 +
 rtl/matmul_flags_sticky_bank.sv | 25 ++
 rtl/matmul_flags_collector.sv | 130 +++++++++++++
 tb/tb_matmul_flags_collector.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matmul_flags_collector_pkg.sv
// Shared constants for the matmul datapath: array geometry and the 2-bit
// flags-collector FSM encodings, also used by the array and the flags register.
package matmul_flags_collector_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int BUS_WIDTH  = 64;
  localparam int MAX_DIM    = BUS_WIDTH / DATA_WIDTH;
  localparam int N          = MAX_DIM * MAX_DIM;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_DRAIN  = 2'd2;
  localparam logic [1:0] ST_COMMIT = 2'd3;

endpackage

// File: rtl/matmul_flags_sticky_bank.sv
// N sticky over/underflow bits; clear beats capture, and only strobes
// qualified by their valid bit are accumulated.
module matmul_flags_sticky_bank #(
  parameter int N = matmul_flags_collector_pkg::N
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         capture,
  input  logic [N-1:0] valid,
  input  logic [N-1:0] ovf,
  output logic [N-1:0] sticky
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky <= '0;
    end else if (clear) begin
      sticky <= '0;
    end else if (capture) begin
      sticky <= sticky | (ovf & valid);
    end
  end

endmodule

// File: rtl/matmul_flags_collector.sv
// Collects per-PE overflow strobes during a matmul, drains, then commits them
// in one write pulse. Define MATMUL_FLAG_COUNT_EN to enable the saturating event counter.
module matmul_flags_collector #(
  parameter int DATA_WIDTH   = matmul_flags_collector_pkg::DATA_WIDTH,
  parameter int BUS_WIDTH    = matmul_flags_collector_pkg::BUS_WIDTH,
  parameter int MAX_DIM      = BUS_WIDTH / DATA_WIDTH,
  parameter int DRAIN_CYCLES = 4,
  parameter int COUNT_WIDTH  = 8,
  localparam int N           = MAX_DIM * MAX_DIM
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic                   abort_i,
  input  logic [N-1:0]           pe_valid_i,
  input  logic [N-1:0]           pe_ovf_i,
  input  logic                   done_i,
  output logic                   flags_we_o,
  output logic [N-1:0]           flags_data_o,
  output logic                   busy_o,
  output logic                   any_flag_o,
  output logic [COUNT_WIDTH-1:0] ovf_count_o
);

  import matmul_flags_collector_pkg::*;

  localparam int CNT_W = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;

  logic [1:0]       state_q;
  logic [CNT_W-1:0] drain_cnt_q;
  logic [N-1:0]     sticky;
  logic             active;
  logic             accept_start;
  logic             do_abort;
  logic             sticky_clear;
  logic             capture;

  assign active       = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign accept_start = (state_q == ST_IDLE) && start_i && !abort_i;
  assign do_abort     = active && abort_i;
  assign sticky_clear = accept_start || do_abort;
  assign capture      = active && !abort_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      drain_cnt_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept_start) state_q <= ST_RUN;
        end
        ST_RUN: begin
          // abort outranks done arriving in the same cycle
          if (abort_i) begin
            state_q <= ST_IDLE;
          end else if (done_i) begin
            if (DRAIN_CYCLES == 0) begin
              state_q <= ST_COMMIT;
            end else begin
              state_q     <= ST_DRAIN;
              drain_cnt_q <= CNT_W'(DRAIN_CYCLES);
            end
          end
        end
        ST_DRAIN: begin
          if (abort_i) begin
            state_q <= ST_IDLE;
          end else begin
            drain_cnt_q <= drain_cnt_q - CNT_W'(1);
            if (drain_cnt_q == CNT_W'(1)) state_q <= ST_COMMIT;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  matmul_flags_sticky_bank #(.N(N)) u_sticky (
    .clk     (clk_i),
    .rst     (rst_i),
    .clear   (sticky_clear),
    .capture (capture),
    .valid   (pe_valid_i),
    .ovf     (pe_ovf_i),
    .sticky  (sticky)
  );

  assign flags_we_o   = (state_q == ST_COMMIT);
  assign busy_o       = (state_q != ST_IDLE);
  assign flags_data_o = sticky;
  assign any_flag_o   = |sticky;

`ifdef MATMUL_FLAG_COUNT_EN
  localparam int unsigned CNT_MAX = (COUNT_WIDTH >= 32) ? 32'hFFFF_FFFF
                                                        : ((32'd1 << COUNT_WIDTH) - 32'd1);

  logic [COUNT_WIDTH-1:0] count_q;

  function automatic int unsigned popcount(input logic [N-1:0] v);
    int unsigned c;
    c = 0;
    for (int i = 0; i < N; i++) c += {31'd0, v[i]};
    return c;
  endfunction

  function automatic logic [COUNT_WIDTH-1:0] sat_add(input logic [COUNT_WIDTH-1:0] a,
                                                     input int unsigned b);
    int unsigned s;
    s = 32'(a) + b;
    if (s > CNT_MAX) return COUNT_WIDTH'(CNT_MAX);
    return COUNT_WIDTH'(s);
  endfunction

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else if (sticky_clear) begin
      count_q <= '0;
    end else if (capture) begin
      count_q <= sat_add(count_q, popcount(pe_ovf_i & pe_valid_i));
    end
  end

  assign ovf_count_o = count_q;
`else
  assign ovf_count_o = '0;
`endif

endmodule

// File: tb/tb_matmul_flags_collector.sv
// Scoreboard bench for matmul_flags_collector: stimulus pushes expected commits,
// a negedge monitor pops and compares whenever flags_we_o is seen.
module tb_matmul_flags_collector;

  localparam int D = 4;
  localparam int N = 4;
`ifdef MATMUL_FLAG_COUNT_EN
  localparam int CW     = 3;
  localparam bit CNT_EN = 1'b1;
`else
  localparam int CW     = 8;
  localparam bit CNT_EN = 1'b0;
`endif
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          start_i, abort_i, done_i;
  logic [N-1:0]  pe_valid_i, pe_ovf_i;
  logic          flags_we_o, busy_o, any_flag_o;
  logic [N-1:0]  flags_data_o;
  logic [CW-1:0] ovf_count_o;

  matmul_flags_collector #(.DRAIN_CYCLES(D), .COUNT_WIDTH(CW)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .start_i      (start_i),
    .abort_i      (abort_i),
    .pe_valid_i   (pe_valid_i),
    .pe_ovf_i     (pe_ovf_i),
    .done_i       (done_i),
    .flags_we_o   (flags_we_o),
    .flags_data_o (flags_data_o),
    .busy_o       (busy_o),
    .any_flag_o   (any_flag_o),
    .ovf_count_o  (ovf_count_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           edge_no;
    logic [N-1:0] vec;
    int           count;
  } exp_t;

  exp_t         sb[$];
  logic [N-1:0] va_q[$];
  logic [N-1:0] ov_q[$];
  logic [N-1:0] hold_vec;
  int           hold_cnt;
  int           checks   = 0;
  int           failures = 0;
  int           cyc      = 0;
  bit           chk_busy_next = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int exp_count(input int sum);
    if (!CNT_EN) return 0;
    return (sum > CMAX) ? CMAX : sum;
  endfunction

  // Monitor: pops one expectation per observed write pulse
  always @(negedge clk) begin
    if (!rst_i) begin
      if (chk_busy_next) begin
        chk("busy_after_commit", {31'd0, busy_o}, 32'd0);
        chk_busy_next = 1'b0;
      end
      if (flags_we_o) begin
        if (sb.size() == 0) begin
          chk("unexpected_we", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("we_timing", cyc, e.edge_no);
          chk("commit_data", {28'd0, flags_data_o}, {28'd0, e.vec});
          chk("commit_any", {31'd0, any_flag_o}, {31'd0, |e.vec});
          chk("commit_count", 32'(ovf_count_o), e.count);
        end
        chk_busy_next = 1'b1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start_i    = 1'b0;
    abort_i    = 1'b0;
    done_i     = 1'($urandom_range(0, 1));
    pe_valid_i = N'($urandom);
    pe_ovf_i   = N'($urandom);
  endtask

  task automatic gap(input int n);
    for (int k = 0; k < n; k++) begin
      idle_inputs();
      step();
    end
    chk("hold_data", {28'd0, flags_data_o}, {28'd0, hold_vec});
    chk("hold_any", {31'd0, any_flag_o}, {31'd0, |hold_vec});
    chk("hold_busy", {31'd0, busy_o}, 32'd0);
    chk("hold_count", 32'(ovf_count_o), hold_cnt);
  endtask

  task automatic fill_zero(input int r);
    va_q.delete();
    ov_q.delete();
    for (int i = 0; i < r + D + 1; i++) begin
      va_q.push_back('0);
      ov_q.push_back('0);
    end
  endtask

  task automatic fill_rand(input int r);
    va_q.delete();
    ov_q.delete();
    for (int i = 0; i < r + D + 1; i++) begin
      va_q.push_back(N'($urandom));
      ov_q.push_back(N'($urandom) & N'($urandom));
    end
  endtask

  // One operation: start, r RUN cycles (done on the last), D drain cycles,
  // then the commit cycle; abort_at indexes those cycles (-1 = none).
  task automatic do_op(input int r, input int abort_at);
    logic [N-1:0] vec;
    int           sum;
    bit           aborted;
    vec     = '0;
    sum     = 0;
    aborted = (abort_at >= 0) && (abort_at < r + D);
    idle_inputs();
    start_i = 1'b1;
    step();
    for (int i = 0; i <= r + D; i++) begin
      pe_valid_i = va_q[i];
      pe_ovf_i   = ov_q[i];
      done_i     = (i == r - 1) ? 1'b1 : ((i >= r) ? 1'($urandom_range(0, 1)) : 1'b0);
      start_i    = ($urandom_range(0, 7) == 0);
      abort_i    = (i == abort_at);
      if (i < r + D) begin
        vec |= va_q[i] & ov_q[i];
        sum += $countones(va_q[i] & ov_q[i]);
      end
      if (i == r + D && !aborted) begin
        sb.push_back('{edge_no: cyc, vec: vec, count: exp_count(sum)});
        hold_vec = vec;
        hold_cnt = exp_count(sum);
      end
      step();
      if (aborted && i == abort_at) begin
        idle_inputs();
        chk("abort_busy", {31'd0, busy_o}, 32'd0);
        chk("abort_data", {28'd0, flags_data_o}, 32'd0);
        chk("abort_we", {31'd0, flags_we_o}, 32'd0);
        hold_vec = '0;
        hold_cnt = 0;
        break;
      end
    end
    idle_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    rst_i      = 1'b1;
    start_i    = 1'b0;
    abort_i    = 1'b0;
    done_i     = 1'b0;
    pe_valid_i = '0;
    pe_ovf_i   = '0;
    hold_vec   = '0;
    hold_cnt   = 0;
    #2;
    chk("rst_we", {31'd0, flags_we_o}, 32'd0);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_any", {31'd0, any_flag_o}, 32'd0);
    chk("rst_data", {28'd0, flags_data_o}, 32'd0);
    chk("rst_count", 32'(ovf_count_o), 32'd0);
    step();
    step();
    rst_i = 1'b0;
    gap(2);

    // Basic: 0101 over all-valid PEs
    fill_zero(3);
    for (int i = 0; i < 3; i++) begin
      va_q[i] = 4'b1111;
      ov_q[i] = 4'b0101;
    end
    do_op(3, -1);
    gap(2);

    // Last drain cycle captured, commit-cycle strobe ignored
    fill_zero(2);
    va_q[2 + 3] = 4'b1111;
    ov_q[2 + 3] = 4'b1000;
    va_q[2 + 4] = 4'b1111;
    ov_q[2 + 4] = 4'b0010;
    do_op(2, -1);
    gap(2);

    // Unqualified strobes never captured
    fill_zero(2);
    for (int i = 0; i < 2; i++) begin
      va_q[i] = 4'b0011;
      ov_q[i] = 4'b1111;
    end
    do_op(2, -1);
    gap(1);

    // Abort two cycles into drain, then a fresh operation
    fill_rand(3);
    do_op(3, 3 + 1);
    gap(1);
    fill_rand(2);
    do_op(2, -1);
    gap(1);

    // Counter saturation: three cycles of four qualified events
    fill_zero(3);
    for (int i = 0; i < 3; i++) begin
      va_q[i] = 4'b1111;
      ov_q[i] = 4'b1111;
    end
    do_op(3, -1);
    gap(2);

    // start and abort together in IDLE: abort wins
    start_i = 1'b1;
    abort_i = 1'b1;
    step();
    idle_inputs();
    chk("start_abort_idle", {31'd0, busy_o}, 32'd0);
    gap(1);

    // Asynchronous reset mid-RUN
    start_i = 1'b1;
    step();
    start_i    = 1'b0;
    done_i     = 1'b0;
    pe_valid_i = 4'b1111;
    pe_ovf_i   = 4'b0110;
    step();
    pe_valid_i = '0;
    pe_ovf_i   = '0;
    step();
    chk("sticky_run", {28'd0, flags_data_o}, 32'h6);
    #2 rst_i = 1'b1;
    #1;
    chk("arst_we", {31'd0, flags_we_o}, 32'd0);
    chk("arst_busy", {31'd0, busy_o}, 32'd0);
    chk("arst_any", {31'd0, any_flag_o}, 32'd0);
    chk("arst_data", {28'd0, flags_data_o}, 32'd0);
    chk("arst_count", 32'(ovf_count_o), 32'd0);
    rst_i = 1'b0;
    step();
    done_i = 1'b1;
    step();
    done_i = 1'b0;
    for (int k = 0; k < D + 3; k++) step();
    chk("arst_no_run", {31'd0, busy_o}, 32'd0);
    hold_vec = '0;
    hold_cnt = 0;

    // Randomized operations, some aborted at random points
    for (int n = 0; n < 30; n++) begin
      r = $urandom_range(1, 6);
      fill_rand(r);
      if ($urandom_range(0, 3) == 0) do_op(r, $urandom_range(0, r + D));
      else do_op(r, -1);
      gap($urandom_range(1, 3));
    end

    step();
    step();
    chk("pending_commits", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
